// File: rtl/instr_fetch_ctrl.sv
// Fetch sequencer: owns the fetch PC and buffers {pc, instr} pairs in a small prefetch FIFO for decode.
// Optional performance counters are built only when FETCH_PERF_EN is defined.
module instr_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4,
    parameter int          PTR_W    = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rd,
    input  logic        halt,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic        misalign_err,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stalls
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic             misalign_q, misalign_d;
    logic [31:0]      pc_mem_q [DEPTH];
    logic [31:0]      pc_mem_d [DEPTH];
    logic [31:0]      instr_mem_q [DEPTH];
    logic [31:0]      instr_mem_d [DEPTH];
    logic             pop;
    logic             push;

    assign pop  = (count_q != '0) & if_ready;
    assign push = !halt & !redirect_valid & ((count_q != FULL_CNT) | pop);

    // Redirect wins over everything: it flushes the queue and drops any same-cycle push/pop.
    always_comb begin
        fetch_pc_d  = fetch_pc_q;
        count_d     = count_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        misalign_d  = misalign_q;
        pc_mem_d    = pc_mem_q;
        instr_mem_d = instr_mem_q;
        if (redirect_valid) begin
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
            if (redirect_pc[1:0] != 2'b00) begin
                misalign_d = 1'b1;
            end
        end else begin
            if (push) begin
                pc_mem_d[wr_ptr_q]    = fetch_pc_q;
                instr_mem_d[wr_ptr_q] = imem_rd;
                wr_ptr_d              = wr_ptr_q + 1'b1;
                fetch_pc_d            = fetch_pc_q + 32'd4;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            misalign_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_q[i]    <= '0;
                instr_mem_q[i] <= '0;
            end
        end else begin
            fetch_pc_q  <= fetch_pc_d;
            count_q     <= count_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            misalign_q  <= misalign_d;
            pc_mem_q    <= pc_mem_d;
            instr_mem_q <= instr_mem_d;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched_q, perf_fetched_d;
    logic [31:0] perf_stalls_q, perf_stalls_d;
    logic        stall;

    assign stall = !halt & !redirect_valid & (count_q == FULL_CNT) & !pop;

    // Both counters saturate instead of wrapping.
    always_comb begin
        perf_fetched_d = perf_fetched_q;
        perf_stalls_d  = perf_stalls_q;
        if (push && (perf_fetched_q != 32'hFFFF_FFFF)) begin
            perf_fetched_d = perf_fetched_q + 32'd1;
        end
        if (stall && (perf_stalls_q != 32'hFFFF_FFFF)) begin
            perf_stalls_d = perf_stalls_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_fetched_q <= '0;
            perf_stalls_q  <= '0;
        end else begin
            perf_fetched_q <= perf_fetched_d;
            perf_stalls_q  <= perf_stalls_d;
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_stalls  = perf_stalls_q;
`else
    assign perf_fetched = 32'd0;
    assign perf_stalls  = 32'd0;
`endif

    assign imem_addr    = fetch_pc_q;
    assign if_valid     = (count_q != '0);
    assign if_instr     = instr_mem_q[rd_ptr_q];
    assign if_pc        = pc_mem_q[rd_ptr_q];
    assign misalign_err = misalign_q;

endmodule
